sb_switch_gen2: RTL and testbench
=================================

SB_SWITCH_GEN2 -- requirements
Module: sb_switch_gen2

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the channel width per side.
REQ-002 The block SHALL have parameter REG_OUT, default 0: 0 = combinational outputs, 1 = outputs registered on prog_clk.
REQ-003 The block SHALL have derived localparam CFG_BITS = 8*W: 4 sides x W bits x 2 select bits.
REQ-004 The block SHALL have port prog_clk, input, 1 bit: the single clock for config and output registers.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port prog_en, input, 1 bit: shift-enable for the shadow chain.
REQ-007 The block SHALL have port prog_in, input, 1 bit: serial config data.
REQ-008 The block SHALL have port prog_commit, input, 1 bit: single-cycle request to transfer shadow to active config.
REQ-009 The block SHALL have ports in1, in2, in3, in4, each input, W bits: side inputs.
REQ-010 The block SHALL have ports out1, out2, out3, out4, each output, W bits: side outputs.
REQ-011 The block SHALL have port prog_out, output, 1 bit: serial chain output, equal to shadow[0].
REQ-012 The block SHALL have port cfg_valid, output, 1 bit: high once a commit has succeeded.
REQ-013 The block SHALL have port cfg_err, output, 1 bit: sticky error flag for a commit with the wrong bit count.

Function
REQ-014 Shadow register, CFG_BITS wide, SHALL shift right when prog_en=1 and the state is not ERR: shadow <= {prog_in, shadow[CFG_BITS-1:1]}.
REQ-015 Shift counter SHALL count accepted shifts.
REQ-016 FSM SHALL have states IDLE (count 0), LOAD (0 < count < CFG_BITS), FULL (count = CFG_BITS) and ERR (overshift).
REQ-017 FSM transitions: IDLE->LOAD on first shift; LOAD->FULL on the CFG_BITS-th shift; FULL->ERR on any further shift.
REQ-018 ERR SHALL ignore further shifts; the shadow is frozen.
REQ-019 On prog_commit in FULL: active <= shadow, cfg_valid <= 1, cfg_err <= 0, counter <= 0, state -> IDLE, all in the same edge.
REQ-020 On prog_commit in IDLE, LOAD or ERR: active unchanged, cfg_err <= 1, counter <= 0, state -> IDLE; shadow contents retained.
REQ-021 If prog_commit and prog_en are both high in one cycle, commit SHALL win and the shift is dropped.
REQ-022 Field for side k (1..4), bit b (0..W-1) SHALL be active[2*((k-1)*W+b) +: 2].
REQ-023 Field codes: 00 = drive 0; 01, 10, 11 = the three other sides in ascending index order.
REQ-024 Example of the code mapping: for out3, 01 = in1, 10 = in2, 11 = in4.
REQ-025 REG_OUT=0: outputs SHALL follow inputs and active config combinationally, with zero latency.
REQ-026 REG_OUT=1: outputs SHALL be registered, giving 1-cycle latency from an input or active-config change.
REQ-027 Active config SHALL change only on a successful commit; shifting never disturbs the routing.
REQ-028 prog_out SHALL always equal shadow[0], so chained instances shift in series.

Reset
REQ-029 rst=1 SHALL asynchronously clear shadow, active, counter, cfg_valid, cfg_err and output registers to 0, and set the state to IDLE.
REQ-030 Consequences of reset: all outputs 0 (every field 00) and prog_out=0.
REQ-031 Reset asserted mid-shift or mid-commit SHALL abandon the operation with no partial commit.
REQ-032 Deassertion SHALL take effect on the next prog_clk edge.

Verification
REQ-033 Reset, W=4, REG_OUT=0, all inputs 4'hF -> all outputs 4'h0, cfg_valid=0, cfg_err=0, prog_out=0.
REQ-034 Shift 32 bits of 0x55555555 (LSB first), then commit, inputs in1=1, in2=2, in3=3, in4=4 -> out1=2, out2=1, out3=1, out4=1, cfg_valid=1.
REQ-035 Shift 31 bits, then commit -> cfg_err=1, outputs unchanged from prior config.
REQ-036 Shift 33 bits, then commit -> state goes to ERR, cfg_err=1, active unchanged.
REQ-037 Reshift 32 bits and commit -> cfg_err clears.
REQ-038 Commit and prog_en high together in FULL -> active = shadow before the dropped shift; counter=0.
REQ-039 Shift 0xFFFFFFFF and commit -> all outputs route 11: out1=in4, out4=in3. Also shift 32 more bits -> prog_out emits the old shadow LSB-first.
REQ-040 REG_OUT=1, change in2 with out1 routed to in2 -> out1 updates exactly 1 cycle later.
REQ-041 Assert rst mid-shift, with async timing checked -> all state zeroed immediately.

Source files
------------

// File: rtl/sb_switch_gen2.sv
// Four-sided switch box with a serially loaded, commit-protected routing config.
// Each output bit selects zero or one of the other three sides' matching bit.
module sb_switch_gen2 #(
    parameter int W       = 4,
    parameter bit REG_OUT = 1'b0
) (
    input  logic         prog_clk,
    input  logic         rst,
    input  logic         prog_en,
    input  logic         prog_in,
    input  logic         prog_commit,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic [W-1:0] out4,
    output logic         prog_out,
    output logic         cfg_valid,
    output logic         cfg_err
);

    localparam int CFG_BITS = 8 * W;
    // One spare count beyond CFG_BITS so the overshift into ERR is representable.
    localparam int CW = $clog2(CFG_BITS + 2);

    typedef enum logic [1:0] {IDLE, LOAD, FULL, ERR} state_t;

    state_t              state_q, state_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                shift_ok;
    logic                commit_ok;
    logic                commit_bad;

    logic [W-1:0]        side_in [4];
    logic [W-1:0]        route   [4];

    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (prog_commit) begin
            state_d = IDLE;
        end else if (prog_en) begin
            unique case (state_q)
                IDLE: state_d = LOAD;
                LOAD: if (cnt_q == CW'(CFG_BITS - 1)) state_d = FULL;
                FULL: state_d = ERR;
                ERR:  state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Commit has priority: a shift requested in the same cycle is dropped.
    always_comb begin
        shift_ok   = prog_en && !prog_commit && (state_q != ERR);
        commit_ok  = prog_commit && (state_q == FULL);
        commit_bad = prog_commit && (state_q != FULL);
    end

    always_comb begin
        shadow_d = shift_ok ? {prog_in, shadow_q[CFG_BITS-1:1]} : shadow_q;
        active_d = commit_ok ? shadow_q : active_q;
        if (prog_commit)   cnt_d = '0;
        else if (shift_ok) cnt_d = cnt_q + CW'(1);
        else               cnt_d = cnt_q;
        valid_d = valid_q | commit_ok;
        if (commit_ok)       err_d = 1'b0;
        else if (commit_bad) err_d = 1'b1;
        else                 err_d = err_q;
    end

    // Code 1..3 picks the other sides in ascending order, skipping the own side.
    always_comb begin
        logic [1:0] code;
        logic [1:0] j;
        logic [1:0] src;
        code       = 2'b00;
        j          = 2'b00;
        src        = 2'b00;
        side_in[0] = in1;
        side_in[1] = in2;
        side_in[2] = in3;
        side_in[3] = in4;
        for (int unsigned s = 0; s < 4; s++) begin
            for (int unsigned b = 0; b < W; b++) begin
                route[s][b] = 1'b0;
                code = active_q[2*(s*W+b) +: 2];
                if (code != 2'b00) begin
                    j   = code - 2'd1;
                    src = (j >= s[1:0]) ? j + 2'd1 : j;
                    route[s][b] = side_in[src][b];
                end
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [W-1:0] out_q [4];
            always_ff @(posedge prog_clk or posedge rst) begin
                if (rst) out_q <= '{default: '0};
                else     out_q <= route;
            end
            assign out1 = out_q[0];
            assign out2 = out_q[1];
            assign out3 = out_q[2];
            assign out4 = out_q[3];
        end else begin : g_comb_out
            assign out1 = route[0];
            assign out2 = route[1];
            assign out3 = route[2];
            assign out4 = route[3];
        end
    endgenerate

    assign prog_out  = shadow_q[0];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_sb_switch_gen2.sv
// Directed bench for sb_switch_gen2: a combinational and a registered-output
// instance share all inputs; expected vectors flow through a scoreboard queue.
module tb_sb_switch_gen2;

    typedef logic [31:0] vec_t;

    logic       prog_clk = 1'b0;
    logic       rst, prog_en, prog_in, prog_commit;
    logic [3:0] in1, in2, in3, in4;
    logic [3:0] a_out1, a_out2, a_out3, a_out4;
    logic [3:0] b_out1, b_out2, b_out3, b_out4;
    logic       a_po, a_v, a_e, b_po, b_v, b_e;
    vec_t       obs_a, obs_b, cap;

    int         tests = 0;
    int         fails = 0;
    vec_t       exp_q [$];
    string      tag_q [$];

    always #5 prog_clk = ~prog_clk;

    sb_switch_gen2 #(.W(4), .REG_OUT(1'b0)) dut_a (
        .prog_clk(prog_clk), .rst(rst), .prog_en(prog_en), .prog_in(prog_in),
        .prog_commit(prog_commit), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .out1(a_out1), .out2(a_out2), .out3(a_out3), .out4(a_out4),
        .prog_out(a_po), .cfg_valid(a_v), .cfg_err(a_e)
    );

    sb_switch_gen2 #(.W(4), .REG_OUT(1'b1)) dut_b (
        .prog_clk(prog_clk), .rst(rst), .prog_en(prog_en), .prog_in(prog_in),
        .prog_commit(prog_commit), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .out1(b_out1), .out2(b_out2), .out3(b_out3), .out4(b_out4),
        .prog_out(b_po), .cfg_valid(b_v), .cfg_err(b_e)
    );

    assign obs_a = {13'b0, a_v, a_e, a_po, a_out4, a_out3, a_out2, a_out1};
    assign obs_b = {13'b0, b_v, b_e, b_po, b_out4, b_out3, b_out2, b_out1};

    function automatic vec_t mk(input logic v, input logic e, input logic p,
                                input logic [3:0] o4, input logic [3:0] o3,
                                input logic [3:0] o2, input logic [3:0] o1);
        return {13'b0, v, e, p, o4, o3, o2, o1};
    endfunction

    task automatic expect_val(input string tag, input vec_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check(input vec_t obs);
        vec_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bits(input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            prog_en = 1'b1;
            prog_in = d[i];
            tick();
        end
        prog_en = 1'b0;
        prog_in = 1'b0;
    endtask

    // Records prog_out ahead of each shift, i.e. the old shadow LSB-first.
    task automatic shift_capture(input logic [31:0] d, output vec_t c);
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c[i]    = a_po;
            prog_en = 1'b1;
            prog_in = d[i];
            tick();
        end
        prog_en = 1'b0;
        prog_in = 1'b0;
    endtask

    task automatic commit();
        prog_commit = 1'b1;
        tick();
        prog_commit = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, required completion before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; prog_en = 1'b0; prog_in = 1'b0; prog_commit = 1'b0;
        in1 = 4'hF; in2 = 4'hF; in3 = 4'hF; in4 = 4'hF;
        #2;
        expect_val("reset_a", mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0)); check(obs_a);
        expect_val("reset_b", mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0)); check(obs_b);

        rst = 1'b0;
        in1 = 4'h1; in2 = 4'h2; in3 = 4'h3; in4 = 4'h4;
        shift_bits(64'h5555_5555, 32);
        expect_val("shift_no_route", mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0)); check(obs_a);
        commit();
        expect_val("commit_55", mk(1, 0, 1, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_a);

        shift_bits(64'hFFFF_FFFF, 31);
        commit();
        expect_val("short_commit", mk(1, 1, 0, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_a);

        // 33 shifts leave shadow = 0xC3A50F9A; the extra zeros in ERR must be ignored.
        shift_bits(64'h1_874A_1F35, 33);
        shift_bits(64'h0, 3);
        expect_val("overshift_frozen", mk(1, 1, 0, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_a);
        commit();
        expect_val("overshift_commit", mk(1, 1, 0, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_a);

        shift_capture(32'hFFFF_FFFF, cap);
        expect_val("err_shadow_emit", 32'hC3A5_0F9A); check(cap);
        commit();
        expect_val("recommit_ok", mk(1, 0, 1, 4'h3, 4'h4, 4'h4, 4'h4)); check(obs_a);

        shift_capture(32'h5555_5555, cap);
        expect_val("all_ones_emit", 32'hFFFF_FFFF); check(cap);

        prog_commit = 1'b1; prog_en = 1'b1; prog_in = 1'b0;
        tick();
        prog_commit = 1'b0; prog_en = 1'b0;
        expect_val("commit_beats_shift", mk(1, 0, 1, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_a);

        shift_bits(64'h0, 32);
        commit();
        expect_val("counter_zeroed", mk(1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0)); check(obs_a);

        shift_bits(64'h5555_5555, 32);
        commit();
        expect_val("regout_comb_now", mk(1, 0, 1, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_a);
        expect_val("regout_lag", mk(1, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0)); check(obs_b);
        tick();
        expect_val("regout_follow", mk(1, 0, 1, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_b);

        in2 = 4'h9;
        #1;
        expect_val("comb_in2", mk(1, 0, 1, 4'h1, 4'h1, 4'h1, 4'h9)); check(obs_a);
        expect_val("reg_in2_hold", mk(1, 0, 1, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_b);
        tick();
        expect_val("reg_in2_update", mk(1, 0, 1, 4'h1, 4'h1, 4'h1, 4'h9)); check(obs_b);

        in2 = 4'h2;
        prog_en = 1'b1; prog_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        expect_val("rst_async_a", mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0)); check(obs_a);
        expect_val("rst_async_b", mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0)); check(obs_b);
        prog_en = 1'b0; prog_in = 1'b0;
        tick();
        rst = 1'b0;
        shift_bits(64'h5555_5555, 32);
        commit();
        expect_val("post_reset_commit", mk(1, 0, 1, 4'h1, 4'h1, 4'h1, 4'h2)); check(obs_a);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
